// File: rtl/event_sched_pkg.sv
// Shared types for the event stream scheduler.
// The filler-word option is EVENT_SCHED_IDLE_FILL_EN.
package event_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TS,
        S_HDR
    } state_t;

    typedef enum logic [1:0] {
        W_EVT,
        W_TS,
        W_HDR,
        W_FILL
    } word_t;

    localparam logic [31:0] IDLE_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/frame_slot_counter.sv
// Data-word slot counter for one frame.
// Saturates at FRAME_LEN; only i_clear returns it to 0.
module frame_slot_counter #(
    parameter int FRAME_LEN = 1022
) (
    input  logic clk,
    input  logic res,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_at_limit
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    logic [CW-1:0] r_count;

    assign o_at_limit = (r_count == CW'(FRAME_LEN));

    always_ff @(posedge clk) begin
        if (!res) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/event_stream_scheduler.sv
// Schedules event/timestamp pairs and frame headers onto one stream.
// Define EVENT_SCHED_IDLE_FILL_EN to pad idle slots with IDLE_WORD pairs.
module event_stream_scheduler
    import event_sched_pkg::*;
#(
    parameter int          FRAME_LEN = 1022,
    parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEF
) (
    input  logic        clk,
    input  logic        res,
    input  logic        evt_valid,
    input  logic [31:0] evt_data,
    input  logic [31:0] evt_time,
    output logic        evt_ready,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    input  logic        new_tx,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        frame_wrap
);

    state_t      r_state;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    word_t       r_out_type;
    logic [31:0] r_hold;
    word_t       r_hold_type;
    logic        r_pend;

    logic w_load;
    logic w_restart;
    logic w_at_limit;
    logic w_evt_sel;
    logic w_fill_sel;
    logic w_ts_sel;
    logic w_hdr_sel;
    logic w_take_evt;
    logic w_take_fill;
    logic w_take_ts;
    logic w_take_hdr;
    logic w_inc;
    logic w_clear;

    assign w_load    = !r_out_valid || out_ready;
    assign w_restart = new_tx || r_pend;

    always_comb begin
        w_evt_sel  = 1'b0;
        w_fill_sel = 1'b0;
        w_ts_sel   = 1'b0;
        w_hdr_sel  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_restart && !w_at_limit) begin
                    w_evt_sel = evt_valid;
`ifdef EVENT_SCHED_IDLE_FILL_EN
                    w_fill_sel = !evt_valid;
`endif
                end
            end
            S_TS:    w_ts_sel  = 1'b1;
            S_HDR:   w_hdr_sel = tx_valid && !new_tx;
            default: ;
        endcase
    end

    assign w_take_evt  = res && w_load && w_evt_sel;
    assign w_take_fill = res && w_load && w_fill_sel;
    assign w_take_ts   = res && w_load && w_ts_sel;
    assign w_take_hdr  = res && w_load && w_hdr_sel;

    assign evt_ready  = w_take_evt;
    assign tx_ready   = w_take_hdr;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_wrap = res && r_out_valid && out_ready
                        && (r_out_type == W_HDR);

    // A pending restart lands as the pair's timestamp leaves
    assign w_inc   = w_take_evt || w_take_fill
                     || (w_take_ts && !w_restart);
    assign w_clear = w_take_hdr
                     || (w_take_ts && w_restart)
                     || ((r_state == S_IDLE) && w_restart)
                     || ((r_state == S_HDR) && new_tx);

    frame_slot_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_slot_cnt (
        .clk        (clk),
        .res        (res),
        .i_inc      (w_inc),
        .i_clear    (w_clear),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_type  <= W_EVT;
            r_hold      <= IDLE_WORD;
            r_hold_type <= W_TS;
            r_pend      <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_take_evt || w_take_fill
                               || w_take_ts || w_take_hdr;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_pend <= 1'b0;
                    if (w_restart) begin
                        r_state <= S_IDLE;
                    end else if (w_at_limit) begin
                        r_state <= S_HDR;
                    end else if (w_take_evt) begin
                        r_out_data  <= evt_data;
                        r_out_type  <= W_EVT;
                        r_hold      <= evt_time;
                        r_hold_type <= W_TS;
                        r_state     <= S_TS;
`ifdef EVENT_SCHED_IDLE_FILL_EN
                    end else if (w_take_fill) begin
                        r_out_data  <= IDLE_WORD;
                        r_out_type  <= W_FILL;
                        r_hold      <= IDLE_WORD;
                        r_hold_type <= W_FILL;
                        r_state     <= S_TS;
`endif
                    end
                end
                S_TS: begin
                    if (w_take_ts) begin
                        r_out_data <= r_hold;
                        r_out_type <= r_hold_type;
                        r_pend     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (new_tx) begin
                        r_pend <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (new_tx) begin
                        r_state <= S_IDLE;
                    end else if (w_take_hdr) begin
                        r_out_data <= tx_data;
                        r_out_type <= W_HDR;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_event_stream_scheduler.sv
// Randomized bench for event_stream_scheduler with a stream-level model.
// Honours EVENT_SCHED_IDLE_FILL_EN when the DUT is built with it.
module tb_event_stream_scheduler;
    import event_sched_pkg::*;

    localparam int FL   = 4;
    localparam int NEV  = 8192;
    localparam int NHDR = 4096;

    logic        clk = 1'b0;
    logic        res;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic [31:0] evt_time;
    logic        evt_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        new_tx;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        frame_wrap;

    always #5 clk = ~clk;

    event_stream_scheduler #(
        .FRAME_LEN (FL),
        .IDLE_WORD (IDLE_WORD_DEF)
    ) dut (
        .clk        (clk),
        .res        (res),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_time   (evt_time),
        .evt_ready  (evt_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .new_tx     (new_tx),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_wrap (frame_wrap)
    );

    logic [31:0] ev_d [NEV];
    logic [31:0] ev_t [NEV];
    logic [31:0] hd   [NHDR];

    int n_vec = 0;
    int n_err = 0;

    // stimulus bookkeeping
    int drv_ev  = 0;
    int drv_hdr = 0;
    bit ev_hs   = 0;
    bit tx_hs   = 0;
    int p_ev, p_tx, p_or, p_new;

    // stream model: words accepted downstream
    int          m_ev    = 0;
    int          m_hdr   = 0;
    int          m_cnt   = 0;
    bit          m_half  = 0;
    bit          m_pend  = 0;
    bit          m_fill  = 0;
    int          n_hdr   = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        if (!evt_valid || ev_hs)
            evt_valid = ($urandom_range(99) < p_ev);
        evt_data = ev_d[drv_ev % NEV];
        evt_time = ev_t[drv_ev % NEV];
        if (!tx_valid || tx_hs)
            tx_valid = ($urandom_range(99) < p_tx);
        tx_data   = hd[drv_hdr % NHDR];
        out_ready = ($urandom_range(99) < p_or);
        new_tx    = ($urandom_range(999) < p_new);
        if (new_tx) out_ready = 1'b1;
    endtask

    task automatic model_cycle();
        bit acc;
        bit hdr_word;
        acc      = out_valid && out_ready;
        hdr_word = 1'b0;
        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, prev_data);
        end
        chk("evt_gate", 32'(evt_ready && !(evt_valid
            && (!out_valid || out_ready))), 32'd0);
        chk("tx_gate", 32'(tx_ready && !(tx_valid
            && (!out_valid || out_ready))), 32'd0);
        chk("rdy_excl", 32'(evt_ready && tx_ready), 32'd0);
        if (!out_valid && !m_half && m_cnt == FL && !new_tx)
            chk("stall_evt", 32'(evt_ready), 32'd0);
        if (acc) begin
            if (m_half) begin
                chk("ts", out_data,
                    m_fill ? IDLE_WORD_DEF : ev_t[(m_ev - 1) % NEV]);
                m_half = 1'b0;
                m_cnt++;
                if (m_pend) begin
                    m_cnt  = 0;
                    m_pend = 1'b0;
                end
            end else if (m_cnt == FL) begin
                chk("hdr", out_data, hd[m_hdr % NHDR]);
                m_hdr++;
                m_cnt    = 0;
                hdr_word = 1'b1;
                n_hdr++;
`ifdef EVENT_SCHED_IDLE_FILL_EN
            end else if (out_data == IDLE_WORD_DEF) begin
                m_fill = 1'b1;
                m_half = 1'b1;
                m_cnt++;
`endif
            end else begin
                chk("evt", out_data, ev_d[m_ev % NEV]);
                m_ev++;
                m_fill = 1'b0;
                m_half = 1'b1;
                m_cnt++;
            end
        end
        chk("wrap", 32'(frame_wrap), 32'(hdr_word));
        if (new_tx) begin
            if (m_half) m_pend = 1'b1;
            else        m_cnt  = 0;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        ev_hs = evt_valid && evt_ready;
        tx_hs = tx_valid && tx_ready;
        if (ev_hs) drv_ev++;
        if (tx_hs) drv_hdr++;
    endtask

    task automatic run(input int n, input int pe, input int pt,
                       input int po, input int pn);
        p_ev = pe; p_tx = pt; p_or = po; p_new = pn;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_inputs();
            #1;
            model_cycle();
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            res = 1'b0;
            drive_inputs();
            #1;
            chk("rst_evt_rdy", 32'(evt_ready), 32'd0);
            chk("rst_tx_rdy", 32'(tx_ready), 32'd0);
            chk("rst_wrap", 32'(frame_wrap), 32'd0);
            ev_hs = 1'b0;
            tx_hs = 1'b0;
        end
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        res       = 1'b1;
        m_cnt     = 0;
        m_half    = 1'b0;
        m_pend    = 1'b0;
        m_ev      = drv_ev;
        m_hdr     = drv_hdr;
        prev_hold = 1'b0;
        drive_inputs();
        #1;
        model_cycle();
    endtask

    initial begin
        for (int i = 0; i < NEV; i++) begin
            ev_d[i] = $urandom() & 32'h7FFF_FFFF;
            ev_t[i] = $urandom();
        end
        for (int i = 0; i < NHDR; i++)
            hd[i] = 32'hA5A5_0000 | 32'(i);
        res       = 1'b0;
        evt_valid = 1'b0;
        evt_data  = '0;
        evt_time  = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        new_tx    = 1'b0;
        out_ready = 1'b0;
        p_ev = 0; p_tx = 0; p_or = 0; p_new = 0;

        do_reset(3);
        run(200, 100, 100, 100, 0);
        run(2000, 70, 80, 70, 20);
        run(300, 100, 0, 100, 0);
        run(300, 100, 100, 100, 0);
        run(2000, 20, 50, 90, 10);
        for (int k = 0; k < 20; k++) begin
            run($urandom_range(30, 3), 90, 90, 80, 30);
            do_reset($urandom_range(2, 1));
        end
        run(1000, 80, 80, 100, 150);
        run(1000, 60, 60, 50, 40);

        chk("progress_evt", 32'(m_ev > 500), 32'd1);
        chk("progress_hdr", 32'(n_hdr > 50), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
